// File: rtl/asteroids_pkg.sv
// Shared types, constants and helpers for the asteroid special stage.
package asteroids_pkg;

  typedef enum logic [1:0] {IDLE, RUN, WON, LOST} stage_state_t;

  localparam int unsigned FRAME_RATE = 30;

  // Widest asteroid vector the hit counter helper accepts.
  localparam int unsigned MAX_ASTEROIDS = 32;

  // Number of set bits in a (zero-extended) hit vector.
  function automatic int unsigned popcount_hits(input logic [MAX_ASTEROIDS-1:0] hits);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_ASTEROIDS; i++) begin
      n += {31'd0, hits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/frame_divider.sv
// Frame-gated modulo-N counter. Advances on each tick while enabled, pulses
// wrap combinationally in the tick cycle where it rolls over from N-1 to 0.
// clear is synchronous and wins over counting.
module frame_divider #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic wrap
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] count_q, count_d;

  assign wrap = enable && tick && (count_q == LAST);

  // Next count: clear, wrap to zero, or step on tick.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && tick) begin
      count_d = wrap ? '0 : count_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/asteroids_stage_ctrl.sv
// Asteroid special stage controller: staggered asteroid release, hit
// counting, stage countdown and win/loss decision.
// Optional build macro ASTEROIDS_RESPAWN_EN recycles hit asteroids by pulsing
// their reset for one clk every RESPAWN_FRAMES frames.
module asteroids_stage_ctrl
  import asteroids_pkg::*;
#(
  parameter int unsigned ASTEROID_COUNT = 6,
  parameter int unsigned SPAWN_FRAMES   = 45,
  parameter int unsigned STAGE_FRAMES   = 900,
  parameter int unsigned HIT_LIMIT      = 3,
  parameter int unsigned RESPAWN_FRAMES = 30
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic                               startOfFrame,
  input  logic                               stage_start,
  input  logic [ASTEROID_COUNT-1:0]          asteroidIsHit,
  output logic [ASTEROID_COUNT-1:0]          asteroid_resetN,
  output logic                               stage_active,
  output logic                               stage_won,
  output logic                               stage_lost,
  output logic [$clog2(HIT_LIMIT+1)-1:0]     hits_taken,
  output logic [$clog2(STAGE_FRAMES+1)-1:0]  frames_left
);

  localparam int unsigned HW = $clog2(HIT_LIMIT + 1);
  localparam int unsigned FW = $clog2(STAGE_FRAMES + 1);
  localparam logic [ASTEROID_COUNT-1:0] ALL_RELEASED = '1;

  stage_state_t state_q, state_d;

  // released: asteroids let out this stage (independent of respawn pulses).
  // seen: asteroids whose hit has already been counted.
  logic [ASTEROID_COUNT-1:0] released_q, released_d;
  logic [ASTEROID_COUNT-1:0] seen_q, seen_d;
  logic [ASTEROID_COUNT-1:0] rst_d;
  logic [FW-1:0]             frames_d;
  logic [HW-1:0]             hits_d;

  logic [ASTEROID_COUNT-1:0] new_hits;
  logic [MAX_ASTEROIDS-1:0]  new_hits_ext;
  logic [ASTEROID_COUNT-1:0] spawn_onehot;
  logic [ASTEROID_COUNT-1:0] respawn_onehot;
  int unsigned               hit_sum;
  logic                      run;
  logic                      spawn_wrap;

  assign run = (state_q == RUN);

  // Flags of asteroids held in reset are ignored; each asteroid counts once.
  assign new_hits = asteroidIsHit & asteroid_resetN & ~seen_q;

  // Widen the new-hit vector for the shared popcount helper.
  always_comb begin
    new_hits_ext = '0;
    new_hits_ext[ASTEROID_COUNT-1:0] = new_hits;
  end

  assign hit_sum = {{(32-HW){1'b0}}, hits_taken} + popcount_hits(new_hits_ext);

  // Lowest asteroid not yet released.
  assign spawn_onehot = ~released_q & (released_q + ASTEROID_COUNT'(1));

  frame_divider #(
    .N (SPAWN_FRAMES)
  ) u_spawn_div (
    .clk    (clk),
    .resetN (resetN),
    .clear  (!run),
    .enable (run && (released_q != ALL_RELEASED)),
    .tick   (startOfFrame),
    .wrap   (spawn_wrap)
  );

`ifdef ASTEROIDS_RESPAWN_EN
  logic pending;
  logic respawn_wrap;

  assign pending = |seen_q;

  frame_divider #(
    .N (RESPAWN_FRAMES)
  ) u_respawn_div (
    .clk    (clk),
    .resetN (resetN),
    .clear  (!run || !pending),
    .enable (run && pending),
    .tick   (startOfFrame),
    .wrap   (respawn_wrap)
  );

  // Lowest pending asteroid is recycled on each respawn wrap.
  assign respawn_onehot = respawn_wrap ? (seen_q & (~seen_q + ASTEROID_COUNT'(1))) : '0;
`else
  assign respawn_onehot = '0;
`endif

  // Stage sequencing, countdown, hit accounting and release masks.
  always_comb begin
    state_d    = state_q;
    frames_d   = frames_left;
    hits_d     = hits_taken;
    seen_d     = seen_q;
    released_d = released_q;
    rst_d      = '0;
    case (state_q)
      RUN: begin
        hits_d = (hit_sum >= HIT_LIMIT) ? HW'(HIT_LIMIT) : HW'(hit_sum);
        seen_d = seen_q | new_hits;
        if (startOfFrame && (frames_left != '0)) begin
          frames_d = frames_left - FW'(1);
        end
        // Loss beats win; both beat spawn and respawn.
        if (hit_sum >= HIT_LIMIT) begin
          state_d = LOST;
        end else if (startOfFrame && (frames_left == FW'(1))) begin
          state_d = WON;
        end else begin
          if (spawn_wrap) begin
            released_d = released_q | spawn_onehot;
          end
          seen_d = seen_d & ~respawn_onehot;
          rst_d  = released_d & ~respawn_onehot;
        end
      end
      default: begin
        if (stage_start) begin
          state_d    = RUN;
          frames_d   = FW'(STAGE_FRAMES);
          hits_d     = '0;
          seen_d     = '0;
          released_d = ASTEROID_COUNT'(1);
          rst_d      = ASTEROID_COUNT'(1);
        end
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q         <= IDLE;
      released_q      <= '0;
      seen_q          <= '0;
      asteroid_resetN <= '0;
      hits_taken      <= '0;
      frames_left     <= FW'(STAGE_FRAMES);
      stage_active    <= 1'b0;
      stage_won       <= 1'b0;
      stage_lost      <= 1'b0;
    end else begin
      state_q         <= state_d;
      released_q      <= released_d;
      seen_q          <= seen_d;
      asteroid_resetN <= rst_d;
      hits_taken      <= hits_d;
      frames_left     <= frames_d;
      stage_active    <= (state_d == RUN);
      stage_won       <= (state_d == WON);
      stage_lost      <= (state_d == LOST);
    end
  end

endmodule

// File: tb/tb_asteroids_stage_ctrl.sv
// Scoreboard bench for asteroids_stage_ctrl with a frame-level reference model.
module tb_asteroids_stage_ctrl;

  localparam int unsigned N_AST = 4;
  localparam int unsigned SPAWN = 3;
  localparam int unsigned STAGE = 20;
  localparam int unsigned HITL  = 3;
  localparam int unsigned RESP  = 2;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       stage_start = 1'b0;
  logic [3:0] asteroidIsHit = '0;
  logic [3:0] asteroid_resetN;
  logic       stage_active, stage_won, stage_lost;
  logic [1:0] hits_taken;
  logic [4:0] frames_left;

  asteroids_stage_ctrl #(
    .ASTEROID_COUNT (N_AST),
    .SPAWN_FRAMES   (SPAWN),
    .STAGE_FRAMES   (STAGE),
    .HIT_LIMIT      (HITL),
    .RESPAWN_FRAMES (RESP)
  ) dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .stage_start     (stage_start),
    .asteroidIsHit   (asteroidIsHit),
    .asteroid_resetN (asteroid_resetN),
    .stage_active    (stage_active),
    .stage_won       (stage_won),
    .stage_lost      (stage_lost),
    .hits_taken      (hits_taken),
    .frames_left     (frames_left)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] rst;
    logic       active;
    logic       won;
    logic       lost;
    logic [1:0] hits;
    logic [4:0] frames;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: phase, frame totals, counted hits.
  localparam int M_IDLE = 0, M_RUN = 1, M_WON = 2, M_LOST = 3;
  int         m_state, m_frames, m_hits, m_run_frames, m_resp;
  logic [3:0] m_seen, m_rst, m_pulse;
  logic [3:0] flags;
  bit         mover_emul;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Asteroids released so far: one at stage entry plus one per SPAWN frames.
  function automatic logic [3:0] released_mask(input int run_frames);
    int n;
    n = 1 + run_frames / SPAWN;
    if (n > N_AST) n = N_AST;
    return 4'((1 << n) - 1);
  endfunction

  function automatic logic [3:0] lowest_bit(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return 4'(1 << i);
    end
    return 4'b0;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_frames = STAGE; m_hits = 0; m_run_frames = 0; m_resp = 0;
    m_seen = '0; m_rst = '0; m_pulse = '0;
  endtask

  task automatic model_step(input bit ss, input bit sof, input logic [3:0] hit);
    logic [3:0] newh, pend;
    int total;
    m_pulse = '0;
    if (m_state != M_RUN) begin
      m_rst = '0;
      if (ss) begin
        m_state = M_RUN; m_frames = STAGE; m_hits = 0; m_run_frames = 0; m_resp = 0;
        m_seen = '0; m_rst = 4'b0001;
      end
    end else begin
      newh   = hit & m_rst & ~m_seen;
      total  = m_hits + $countones(newh);
      pend   = m_seen;
      m_seen = m_seen | newh;
      m_hits = (total >= HITL) ? HITL : total;
      if (sof) m_frames--;
      if (total >= HITL) begin
        m_state = M_LOST; m_rst = '0;
      end else if (sof && m_frames == 0) begin
        m_state = M_WON; m_rst = '0;
      end else begin
        if (sof) m_run_frames++;
`ifdef ASTEROIDS_RESPAWN_EN
        if (pend == 0) m_resp = 0;
        else if (sof) begin
          m_resp++;
          if (m_resp == RESP) begin
            m_resp = 0;
            m_pulse = lowest_bit(pend);
          end
        end
`endif
        m_seen = m_seen & ~m_pulse;
        m_rst  = released_mask(m_run_frames) & ~m_pulse;
      end
    end
  endtask

  // One clk of stimulus; expected post-edge outputs go to the scoreboard.
  task automatic cycle(input bit ss, input bit sof);
    exp_t e;
    @(negedge clk);
    stage_start = ss; startOfFrame = sof; asteroidIsHit = flags;
    model_step(ss, sof, flags);
    // Movers clear their own flag while held in reset.
    if (mover_emul) flags = flags & m_rst;
    e.rst = m_rst; e.active = (m_state == M_RUN); e.won = (m_state == M_WON);
    e.lost = (m_state == M_LOST); e.hits = 2'(m_hits); e.frames = 5'(m_frames);
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0; stage_start = 1'b0; startOfFrame = 1'b0;
    #1;
    check("reset_asteroid_resetN", 32'(asteroid_resetN), 0);
    check("reset_stage_active", 32'(stage_active), 0);
    check("reset_stage_won", 32'(stage_won), 0);
    check("reset_stage_lost", 32'(stage_lost), 0);
    check("reset_hits_taken", 32'(hits_taken), 0);
    check("reset_frames_left", 32'(frames_left), STAGE);
    model_reset();
    flags = '0; asteroidIsHit = '0;
    @(negedge clk);
    resetN = 1'b1;
  endtask

  // Monitor: compare each scheduled expectation just after its clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("asteroid_resetN", 32'(asteroid_resetN), 32'(e.rst));
        check("stage_active", 32'(stage_active), 32'(e.active));
        check("stage_won", 32'(stage_won), 32'(e.won));
        check("stage_lost", 32'(stage_lost), 32'(e.lost));
        check("hits_taken", 32'(hits_taken), 32'(e.hits));
        check("frames_left", 32'(frames_left), 32'(e.frames));
      end
    end
  end

  initial begin
    int idx;
    model_reset();
    flags = '0;
    mover_emul = 1'b1;
    do_reset();

    // Spawn sequence and win by timeout, with stray stage_start pulses.
    cycle(1, 0);
    settle();
    check("entry_asteroid_resetN", 32'(asteroid_resetN), 32'h1);
    check("entry_frames_left", 32'(frames_left), STAGE);
    for (int i = 0; i < 200 && m_state == M_RUN; i++) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
    end
    check("timeout_reached", 32'(m_state), M_WON);
    repeat (3) cycle(0, 0);

    // Held flag counts once; two simultaneous new hits end the stage.
    cycle(1, 0);
    for (int i = 0; i < 18; i++) cycle(0, i % 2 == 1);
    flags[1] = 1'b1;
    for (int i = 0; i < 50; i++) cycle(0, i % 10 == 9);
    flags = flags | 4'b0101;
    cycle(0, 0);
    repeat (3) cycle(0, 0);

    // Flag from an unreleased asteroid is ignored; then win.
    cycle(1, 0);
    mover_emul = 1'b0;
    flags = 4'b1000;
    for (int i = 0; i < 6; i++) cycle(0, 1);
    flags = '0;
    mover_emul = 1'b1;
    for (int i = 0; i < 40 && m_state == M_RUN; i++) cycle(0, 1);
    repeat (2) cycle(0, 0);

    // Third hit lands on the same clk as the last frame: loss wins.
    cycle(1, 0);
    for (int i = 1; i <= 19; i++) begin
      if (i == 1) flags[0] = 1'b1;
      if (i == 5) flags[1] = 1'b1;
      cycle(0, 1);
    end
    flags[2] = 1'b1;
    cycle(0, 1);
    settle();
    check("simul_stage_lost", 32'(stage_lost), 1);
    check("simul_stage_won", 32'(stage_won), 0);
    repeat (2) cycle(0, 0);

    // Asynchronous reset in the middle of a stage.
    cycle(1, 0);
    flags = '0;
    for (int i = 0; i < 7; i++) cycle(0, 1);
    settle();
    do_reset();

    // Randomised stages.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        idx = $urandom_range(0, 3);
        flags[idx] = 1'b1;
      end
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
